store_data_packer: RTL and testbench

- Write-side counterpart of the load-path sign/zero extension in the MIPS datapath.
- Takes a store request (SB/SH/SW size, byte address, rt register value) and replicates the data into the correct byte lanes.
- Generates a per-byte write strobe and a word-aligned address, and presents the result to data memory through a registered valid/ready stage.
- Detects misaligned and illegal-size stores and reports them as a one-cycle fault instead of writing memory.

---
 rtl/store_data_packer.sv | 155 +++++++++++++++
 tb/tb_store_data_packer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_data_packer.sv
// MIPS store-side byte-lane packer: replicates SB/SH/SW data into lanes, builds strobes and
// a word address, and flags misaligned/reserved-size stores. STORE_PACK_STATS_EN adds counters.
module store_data_packer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_size,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic [1:0]        err_code,
  output logic [15:0]       stat_stores,
  output logic [15:0]       stat_faults
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_SIZE     = 2'b10;

  function automatic logic [31:0] pack_data(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    case (size)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] pack_strb(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] r;
    r = 4'b1111;
    case (size)
      SZ_BYTE: r = 4'b0001 << a;
      SZ_HALF: r = a[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Reserved size outranks misalignment.
  function automatic logic [1:0] fault_code(input logic [1:0] size, input logic [1:0] a);
    logic [1:0] r;
    r = ERR_NONE;
    case (size)
      SZ_BYTE: r = ERR_NONE;
      SZ_HALF: r = a[0] ? ERR_MISALIGN : ERR_NONE;
      SZ_WORD: r = (a != 2'b00) ? ERR_MISALIGN : ERR_NONE;
      default: r = ERR_SIZE;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  // Stage p0: combinational decode of the incoming request
  logic              vld_p1;
  logic              accept_p0;
  logic              fault_p0;
  logic [1:0]        code_p0;
  logic [31:0]       wdata_p0;
  logic [3:0]        wstrb_p0;
  logic [ADDR_W-1:0] waddr_p0;

  assign in_ready  = rst & (~vld_p1 | mem_ready);
  assign accept_p0 = in_valid & in_ready;
  assign code_p0   = fault_code(in_size, in_addr[1:0]);
  assign fault_p0  = (code_p0 != ERR_NONE);
  assign wdata_p0  = pack_data(in_size, in_data);
  assign wstrb_p0  = pack_strb(in_size, in_addr[1:0]);
  assign waddr_p0  = {in_addr[ADDR_W-1:2], 2'b00};

  // Stage p1: registered memory request and fault report
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       wdata_p1;
  logic [3:0]        wstrb_p1;
  logic              err_vld_p1;
  logic [ADDR_W-1:0] err_addr_p1;
  logic [1:0]        err_code_p1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1      <= 1'b0;
      addr_p1     <= '0;
      wdata_p1    <= '0;
      wstrb_p1    <= '0;
      err_vld_p1  <= 1'b0;
      err_addr_p1 <= '0;
      err_code_p1 <= ERR_NONE;
    end else begin
      if (accept_p0 && !fault_p0) begin
        vld_p1   <= 1'b1;
        addr_p1  <= waddr_p0;
        wdata_p1 <= wdata_p0;
        wstrb_p1 <= wstrb_p0;
      end else if (mem_ready) begin
        vld_p1 <= 1'b0;
      end
      err_vld_p1 <= accept_p0 & fault_p0;
      if (accept_p0 && fault_p0) begin
        err_addr_p1 <= in_addr;
        err_code_p1 <= code_p0;
      end
    end
  end

  assign mem_valid = vld_p1;
  assign mem_addr  = addr_p1;
  assign mem_wdata = wdata_p1;
  assign mem_wstrb = wstrb_p1;
  assign err_valid = err_vld_p1;
  assign err_addr  = err_addr_p1;
  assign err_code  = err_code_p1;

`ifdef STORE_PACK_STATS_EN
  logic [15:0] stores_p1;
  logic [15:0] faults_p1;

  // The fault count moves on the same edge that raises err_valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stores_p1 <= '0;
      faults_p1 <= '0;
    end else begin
      if (vld_p1 && mem_ready)
        stores_p1 <= sat_inc(stores_p1);
      if (accept_p0 && fault_p0)
        faults_p1 <= sat_inc(faults_p1);
    end
  end

  assign stat_stores = stores_p1;
  assign stat_faults = faults_p1;
`else
  assign stat_stores = 16'd0;
  assign stat_faults = 16'd0;
`endif

endmodule

// File: tb/tb_store_data_packer.sv
// Bench for store_data_packer: directed steps then random traffic against a spec-level model.
module tb_store_data_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_size;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        err_valid;
  logic [31:0] err_addr;
  logic [1:0]  err_code;
  logic [15:0] stat_stores;
  logic [15:0] stat_faults;

  int nvec = 0;
  int nerr = 0;

  // Reference state: what the outputs should show after the last edge
  logic        m_pend;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_err;
  logic [31:0] m_err_addr;
  logic [1:0]  m_err_code;
  int          m_stores, m_faults;

  always #5 clk = ~clk;

  store_data_packer #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_size(in_size),
    .in_addr(in_addr), .in_data(in_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .err_valid(err_valid), .err_addr(err_addr), .err_code(err_code),
    .stat_stores(stat_stores), .stat_faults(stat_faults)
  );

  function automatic logic [31:0] ref_data(input int sz, input logic [31:0] d);
    if (sz == 0) return (d & 32'hFF) * 32'h01010101;
    if (sz == 1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [3:0] ref_strb(input int sz, input logic [31:0] addr);
    int off;
    off = int'(addr % 4);
    if (sz == 0) return 4'(1 << off);
    if (sz == 1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [1:0] ref_code(input int sz, input logic [31:0] addr);
    if (sz == 3) return 2'd2;
    if ((addr % (32'd1 << sz)) != 0) return 2'd1;
    return 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare all outputs mid-cycle, advance the model, then cross the edge.
  task automatic tick();
    logic exp_ready, acc;
    int   sz;
    @(negedge clk);
    exp_ready = rst && (!m_pend || mem_ready);
    chk("in_ready",  32'(in_ready),  32'(exp_ready));
    chk("mem_valid", 32'(mem_valid), 32'(m_pend));
    chk("mem_addr",  mem_addr,       m_addr);
    chk("mem_wdata", mem_wdata,      m_wdata);
    chk("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
    chk("err_valid", 32'(err_valid), 32'(m_err));
    chk("err_addr",  err_addr,       m_err_addr);
    chk("err_code",  32'(err_code),  32'(m_err_code));
`ifdef STORE_PACK_STATS_EN
    chk("stat_stores", 32'(stat_stores), 32'(m_stores));
    chk("stat_faults", 32'(stat_faults), 32'(m_faults));
`else
    chk("stat_stores", 32'(stat_stores), 32'd0);
    chk("stat_faults", 32'(stat_faults), 32'd0);
`endif
    acc = in_valid && exp_ready;
    sz  = int'(in_size);
    m_err = 1'b0;
    if (!rst) begin
      m_pend = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
      m_err_addr = 0; m_err_code = 0; m_stores = 0; m_faults = 0;
    end else begin
      if (m_pend && mem_ready) begin
        m_stores = m_stores + 1;
        m_pend = 1'b0;
      end
      if (acc) begin
        if (ref_code(sz, in_addr) == 2'd0) begin
          m_pend  = 1'b1;
          m_addr  = in_addr - (in_addr % 4);
          m_wdata = ref_data(sz, in_data);
          m_wstrb = ref_strb(sz, in_addr);
        end else begin
          m_err      = 1'b1;
          m_err_addr = in_addr;
          m_err_code = ref_code(sz, in_addr);
          m_faults   = m_faults + 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    in_valid = 1'b1; in_size = sz; in_addr = a; in_data = d;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_size = 0; in_addr = 0; in_data = 0; mem_ready = 1'b1;
    m_pend = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
    m_err = 0; m_err_addr = 0; m_err_code = 0; m_stores = 0; m_faults = 0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // SB to 0x1003
    req(2'b00, 32'h1003, 32'h123456AB);
    tick();
    in_valid = 1'b0;
    chk("sb_valid", 32'(mem_valid), 32'd1);
    chk("sb_addr",  mem_addr,       32'h1000);
    chk("sb_wdata", mem_wdata,      32'hABABABAB);
    chk("sb_wstrb", 32'(mem_wstrb), 32'h8);
    tick();

    // SH then SW back to back
    req(2'b01, 32'h2002, 32'hDEADBEEF);
    tick();
    chk("sh_wdata", mem_wdata,      32'hBEEFBEEF);
    chk("sh_wstrb", 32'(mem_wstrb), 32'hC);
    req(2'b10, 32'h2004, 32'hCAFEF00D);
    tick();
    chk("sw_valid", 32'(mem_valid), 32'd1);
    chk("sw_wdata", mem_wdata,      32'hCAFEF00D);
    chk("sw_wstrb", 32'(mem_wstrb), 32'hF);

    // Misaligned word, then reserved size
    req(2'b10, 32'h3001, 32'h0);
    tick();
    chk("mis_memvalid", 32'(mem_valid), 32'd0);
    chk("mis_err",      32'(err_valid), 32'd1);
    chk("mis_addr",     err_addr,       32'h3001);
    chk("mis_code",     32'(err_code),  32'd1);
    req(2'b11, 32'h4000, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("rsv_err",  32'(err_valid), 32'd1);
    chk("rsv_code", 32'(err_code),  32'd2);
    tick();
    chk("err_pulse_end", 32'(err_valid), 32'd0);

    // Stall for 3 cycles after SB to 0
    req(2'b00, 32'h0, 32'h55);
    mem_ready = 1'b0;
    tick();
    in_valid = 1'b1; in_size = 2'b10; in_addr = 32'h8; in_data = 32'h1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    mem_ready = 1'b1;
    tick();
    chk("stall_ready", 32'(in_ready), 32'd1);

    // Fifth legal store, then stats
    req(2'b10, 32'h5000, 32'h12345678);
    tick();
    in_valid = 1'b0;
    tick(); tick();
`ifdef STORE_PACK_STATS_EN
    chk("stats_stores5", 32'(stat_stores), 32'd5);
    chk("stats_faults2", 32'(stat_faults), 32'd2);
`else
    chk("stats_off_s", 32'(stat_stores), 32'd0);
    chk("stats_off_f", 32'(stat_faults), 32'd0);
`endif

    // Reset during a stall discards the pending write
    req(2'b01, 32'h6002, 32'hAAAA5555);
    mem_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_wdata", mem_wdata,      32'd0);
    chk("rst_ready", 32'(in_ready),  32'd0);
    rst = 1'b1; mem_ready = 1'b1;
    tick(); tick();
    chk("rst_no_replay", 32'(mem_valid), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_size   = 2'($urandom_range(0, 3));
      in_addr   = $urandom;
      in_data   = $urandom;
      mem_ready = ($urandom_range(0, 9) < 6);
      rst       = ($urandom_range(0, 59) != 0);
      tick();
    end
    rst = 1'b1; in_valid = 1'b0; mem_ready = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
